carry_select_multiword_seq: RTL and testbench
=============================================

// Module: carry_select_multiword_seq
// PURPOSE
//  Multi-precision add/subtract sequencer time-sharing one carry_select_adder_16bit.
//  Accepts a WORDS*16-bit operand pair on a valid/ready handshake, then feeds one 16-bit limb per cycle, LSB limb first.
//  Chains the limb carry through a register and returns the full-width result on a second valid/ready handshake.
//  Sits between wide-datapath users and the single shared 16-bit carry select adder.
// PARAMETERS
//  WORDS  4  number of 16-bit limbs; operand/result width = 16*WORDS; legal range 2..16
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         request valid
//  in_ready   out  1         block idle, can accept request
//  op_a       in   16*WORDS  operand A
//  op_b       in   16*WORDS  operand B
//  c_in       in   1         carry-in for add / borrow-in for subtract
//  sub        in   1         0: A+B+c_in   1: A-B-c_in
//  out_valid  out  1         result valid, held until accepted
//  out_ready  in   1         consumer accepts result
//  sum        out  16*WORDS  result
//  c_out      out  1         raw final carry (for subtract: 1 = no borrow)
//  ovf        out  1         two's-complement signed overflow of full-width result
//  busy       out  1         high in RUN and DONE
// BEHAVIOUR
//  States: IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE); busy = !in_ready.
//  IDLE: on in_valid: capture op_a, op_b^{16*WORDS{sub}}, first carry = c_in^sub, sub; limb index = 0; enter RUN.
//  RUN: adder a = A limb[idx], b = B_eff limb[idx], c_in = carry_q.
//   Each cycle: write s into sum limb[idx]; carry_q <= c_out; idx++.
//   At idx==WORDS-1: register c_out and ovf; enter DONE.
//  ovf = (A_msb == B_eff_msb) && (sum_msb != A_msb).
//  Latency: accept edge to out_valid = WORDS cycles. out_valid = (state==DONE).
//  DONE: sum/c_out/ovf held stable while out_valid && !out_ready.
//   On out_valid && out_ready, return to IDLE. in_ready rises the following cycle, with no same-cycle bypass.
//   Max throughput: one op per WORDS+2 cycles.
//  in_valid during RUN/DONE is ignored; op_a/op_b/c_in/sub are sampled only on the accept edge.
//  Wrap-around: all-ones + 1 yields sum=0 and c_out=1. Carry propagates across every limb boundary.
//  Reset (asynchronous, any state, including mid-RUN):
//   state=IDLE, idx=0, carry_q=0, sum=0, c_out=0, ovf=0, out_valid=0, busy=0, in_ready=1.
//   The partial operation is discarded; no output pulses.
//  Limb index counter width = $clog2(WORDS); no wrap beyond WORDS-1.
// STRUCTURE
//  carry_select_pkg holds:
//   - LIMB_W=16
//   - state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2)
//  Single sub-module: one instance of carry_select_adder_16bit (ports a, b, c_in, s, c_out).
//  Remaining logic in this module: FSM, limb counter, operand/result registers, limb mux/demux.
// TESTING (WORDS=4)
//  1 Reset: assert rst_n=0 mid-sim -> in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0 asynchronously.
//  2 Add wrap: A=64'hFFFF_FFFF_FFFF_FFFF, B=1, c_in=0 -> sum=0, c_out=1, ovf=0; out_valid exactly 4 cycles after accept.
//  3 Subtract: A=5, B=3, sub=1 -> sum=2, c_out=1. Then A=3, B=5 -> sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0.
//  4 Signed overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> sum=64'h8000_0000_0000_0000, ovf=1, c_out=0.
//  5 Backpressure: hold out_ready=0 for 5 cycles; toggle in_valid/op_a meanwhile -> sum unchanged, in_ready=0.
//    Then release -> one transfer; in_ready=1 the next cycle.
//  6 Reset mid-RUN: assert rst_n after 2 RUN cycles -> IDLE, no out_valid.
//    Then new op A=64'h0000_0000_0000_FFFF, B=1 -> sum=64'h0000_0000_0001_0000.

Source files
------------

// File: rtl/carry_select_pkg.sv
// Shared definitions for the multi-word carry-select add/subtract sequencer:
// limb width and the sequencer state encoding.
package carry_select_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder built from 4-bit blocks. Every block precomputes
// its sum for both possible incoming carries; the real carry only drives a
// mux chain, so no ripple runs through the block adders.
module carry_select_adder_16bit
    import carry_select_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              c_in,
    output logic [LIMB_W-1:0] s,
    output logic              c_out
);

    localparam int BLK_W = 4;
    localparam int NBLK  = LIMB_W / BLK_W;

    logic [NBLK:0] carry;

    assign carry[0] = c_in;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK_W:0] sum0;
        logic [BLK_W:0] sum1;

        // Both candidate sums; a+b is at most 2^(BLK_W+1)-2, so +1 cannot overflow.
        assign sum0 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
        assign sum1 = sum0 + (BLK_W+1)'(1);

        assign s[g*BLK_W +: BLK_W] = carry[g] ? sum1[BLK_W-1:0] : sum0[BLK_W-1:0];
        assign carry[g+1]          = carry[g] ? sum1[BLK_W]     : sum0[BLK_W];
    end

    assign c_out = carry[NBLK];

endmodule

// File: rtl/carry_select_multiword_seq.sv
// Multi-precision add/subtract sequencer. A WORDS*16-bit request is captured
// on the input handshake, then one 16-bit limb per cycle (LSB first) is pushed
// through a single shared carry-select adder, with the limb carry chained
// through carry_q. The full result is offered on the output handshake.
// Subtraction is done as A + ~B + ~borrow_in, so c_out=1 means "no borrow".
module carry_select_multiword_seq
    import carry_select_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*WORDS-1:0] op_a,
    input  logic [LIMB_W*WORDS-1:0] op_b,
    input  logic                    c_in,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*WORDS-1:0] sum,
    output logic                    c_out,
    output logic                    ovf,
    output logic                    busy
);

    localparam int             IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e state_q;
    state_e state_d;

    logic [IDX_W-1:0]              idx_q;
    logic [WORDS-1:0][LIMB_W-1:0]  a_q;
    logic [WORDS-1:0][LIMB_W-1:0]  b_q;      // B already conditionally inverted
    logic [WORDS-1:0][LIMB_W-1:0]  sum_q;
    logic                          carry_q;
    logic                          c_out_q;
    logic                          ovf_q;

    logic                          accept;
    logic                          last_limb;
    logic [LIMB_W-1:0]             add_a;
    logic [LIMB_W-1:0]             add_b;
    logic [LIMB_W-1:0]             add_s;
    logic                          add_c_out;
    logic                          a_msb;
    logic                          b_msb;

    assign accept    = in_valid && in_ready;
    assign last_limb = (state_q == S_RUN) && (idx_q == LAST_IDX);

    // Limb mux into the shared adder; the limb index selects the active slice.
    assign add_a = a_q[idx_q];
    assign add_b = b_q[idx_q];

    carry_select_adder_16bit u_adder (
        .a     (add_a),
        .b     (add_b),
        .c_in  (carry_q),
        .s     (add_s),
        .c_out (add_c_out)
    );

    // Signed overflow of the whole word only depends on the top limb.
    assign a_msb = a_q[WORDS-1][LIMB_W-1];
    assign b_msb = b_q[WORDS-1][LIMB_W-1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always updated with non-blocking assignments
        // so every flop samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, decoded purely from the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Return to IDLE only; in_ready rises a cycle later (no bypass).
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand capture, limb counter, carry chain and result demux.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand registers are reset too; they are few flops and a
        // known value keeps the adder inputs defined straight out of reset.
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b ^ {(LIMB_W*WORDS){sub}};
            carry_q <= c_in ^ sub;
            idx_q   <= '0;
        end else if (state_q == S_RUN) begin
            sum_q[idx_q] <= add_s;
            carry_q      <= add_c_out;
            if (last_limb) begin
                c_out_q <= add_c_out;
                ovf_q   <= (a_msb == b_msb) && (add_s[LIMB_W-1] != a_msb);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_carry_select_multiword_seq.sv
// Directed bench for carry_select_multiword_seq with WORDS=4 (64-bit operands).
module tb_carry_select_multiword_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;

    carry_select_multiword_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Present a request at a negedge, let it be accepted on the next posedge,
    // then scramble the inputs to prove they are only sampled on accept.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic s);
        @(negedge clk);
        op_a = a; op_b = b; c_in = ci; sub = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b; c_in = ~ci; sub = ~s;
    endtask

    // Count posedges from the accept edge until out_valid, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (1) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid === 1'b1 || cyc >= 20) break;
        end
        if (out_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL wait_done: out_valid not seen within %0d cycles", cyc);
        end
        @(negedge clk);
    endtask

    // Complete the output handshake; in_ready must stay low in the handshake
    // cycle and rise only on the following one.
    task automatic finish_op(input string name);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL %s_ready_in_done: got %b expected 0", name, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_after_xfer: got out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s,
                          output logic [W-1:0] r_sum, output logic r_c, output logic r_o,
                          output int cyc);
        start_op(a, b, ci, s);
        wait_done(cyc);
        r_sum = sum; r_c = c_out; r_o = ovf;
        finish_op(name);
    endtask

    // Compares one completed operation against hand-computed values.
    task automatic expect_result(input string name, input logic [W-1:0] r_sum, input logic r_c,
                                 input logic r_o, input int cyc,
                                 input logic [W-1:0] e_sum, input logic e_c, input logic e_o);
        checks++;
        if (r_sum !== e_sum) begin
            failures++; $display("FAIL %s_sum: got %h expected %h", name, r_sum, e_sum);
        end
        checks++;
        if (r_c !== e_c) begin
            failures++; $display("FAIL %s_c_out: got %b expected %b", name, r_c, e_c);
        end
        checks++;
        if (r_o !== e_o) begin
            failures++; $display("FAIL %s_ovf: got %b expected %b", name, r_o, e_o);
        end
        checks++;
        if (cyc !== WORDS) begin
            failures++; $display("FAIL %s_latency: got %0d expected %0d", name, cyc, WORDS);
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL %s: got in_ready=%b out_valid=%b busy=%b sum=%h c_out=%b ovf=%b expected 1/0/0/0/0/0",
                     name, in_ready, out_valid, busy, sum, c_out, ovf);
        end
    endtask

    task automatic test_reset();
        int cyc;
        #12;
        check_idle_zero("reset_hold");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_release");
        // Park a result in DONE, then reset asynchronously between clock edges.
        start_op(64'h1, 64'h1, 1'b0, 1'b0);
        wait_done(cyc);
        checks++;
        if (sum !== 64'h2 || busy !== 1'b1) begin
            failures++; $display("FAIL reset_pre_sum: got sum=%h busy=%b expected 2/1", sum, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("reset_async_done");
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [W-1:0] s; logic c, o; int cyc;
        run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s, c, o, cyc);
        expect_result("add_wrap", s, c, o, cyc, 64'h0, 1'b1, 1'b0);
        run_op("add_chain", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, s, c, o, cyc);
        expect_result("add_chain", s, c, o, cyc, 64'h0, 1'b1, 1'b0);
        run_op("add_limb", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, s, c, o, cyc);
        expect_result("add_limb", s, c, o, cyc, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        logic [W-1:0] s; logic c, o; int cyc;
        run_op("sub_pos", 64'h5, 64'h3, 1'b0, 1'b1, s, c, o, cyc);
        expect_result("sub_pos", s, c, o, cyc, 64'h2, 1'b1, 1'b0);
        run_op("sub_neg", 64'h3, 64'h5, 1'b0, 1'b1, s, c, o, cyc);
        expect_result("sub_neg", s, c, o, cyc, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_borrow_in", 64'h10, 64'h5, 1'b1, 1'b1, s, c, o, cyc);
        expect_result("sub_borrow_in", s, c, o, cyc, 64'hA, 1'b1, 1'b0);
    endtask

    task automatic test_ovf();
        logic [W-1:0] s; logic c, o; int cyc;
        run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s, c, o, cyc);
        expect_result("ovf_add", s, c, o, cyc, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, s, c, o, cyc);
        expect_result("ovf_sub", s, c, o, cyc, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        int cyc;
        start_op(64'h1234, 64'h1111, 1'b0, 1'b0);
        wait_done(cyc);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            op_a = 64'(i) * 64'h0101_0101_0101_0101;
            checks++;
            if (sum !== 64'h2345 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: got sum=%h out_valid=%b in_ready=%b expected 2345/1/0",
                         i, sum, out_valid, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        finish_op("bp_release");
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_single_xfer: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] s; logic c, o; int cyc;
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("rst_mid_run");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rst_mid_quiet_%0d: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
            end
        end
        run_op("rst_mid_new", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, s, c, o, cyc);
        expect_result("rst_mid_new", s, c, o, cyc, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
